snitch_icache_refill_arbiter: RTL and testbench
===============================================

# snitch_icache_refill_arbiter

Shares the single L1 lookup/refill port of the instruction cache among `NR_FETCH_PORTS` L0 miss handlers. Arbitration is round-robin with a stable grant. Each downstream request is tagged with the requester index, and each response is routed back by that tag. Per-port outstanding counters bound in-flight misses. The block sits between the per-core L0 caches and the shared L1 lookup stage.

## Interface
- `NR_FETCH_PORTS`, default 4: number of requesters, 2..16.
- `FETCH_AW`, default 32: request address width.
- `LINE_WIDTH`, default 128: response line width.
- `MAX_OUTSTANDING`, default 2: maximum in-flight requests per port, 1..7.
- `ID_WIDTH`, default `$clog2(NR_FETCH_PORTS)`: tag width (derived).
- `clk_i` in, 1: the single clock.
- `rst_i` in, 1: reset; synchronous and active-high.
- `in_addr_i` in, `NR_FETCH_PORTS`×`FETCH_AW`: per-port miss address.
- `in_valid_i` in, `NR_FETCH_PORTS`: per-port request valid.
- `in_ready_o` out, `NR_FETCH_PORTS`: per-port request ready.
- `in_rsp_data_o` out, `LINE_WIDTH`: response line, broadcast to all ports.
- `in_rsp_error_o` out, 1: response error, broadcast.
- `in_rsp_valid_o` out, `NR_FETCH_PORTS`: one-hot response valid.
- `in_rsp_ready_i` in, `NR_FETCH_PORTS`: per-port response ready.
- `out_addr_o` out, `FETCH_AW`: downstream address.
- `out_id_o` out, `ID_WIDTH`: downstream tag, equal to the requester index.
- `out_valid_o` out, 1: downstream valid.
- `out_ready_i` in, 1: downstream ready.
- `out_rsp_data_i` in, `LINE_WIDTH`: downstream response line.
- `out_rsp_error_i` in, 1: downstream response error.
- `out_rsp_id_i` in, `ID_WIDTH`: downstream response tag.
- `out_rsp_valid_i` in, 1: downstream response valid.
- `out_rsp_ready_o` out, 1: downstream response ready.
- `stall_cnt_o` out, `NR_FETCH_PORTS`×16: per-port stall counters; only present with `SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN`.

## Operation
- A port is eligible when `in_valid_i[p]` is high and `outstanding[p] < MAX_OUTSTANDING`.
- Arbitration states:
  - IDLE: select the first eligible port at or after `rr_ptr`, wrapping modulo `NR_FETCH_PORTS`. Drive `out_*` combinationally from that port. If `out_ready_i` is low, latch the grant and enter LOCKED.
  - LOCKED: the grant is held on the latched port, whatever other requests arrive. Return to IDLE on handshake.
- Handshake on port p: `in_ready_o[p] = out_ready_i` for the granted port only; all other ready bits are 0.
- On handshake: `rr_ptr <= p+1` (wrapping) and `outstanding[p]++`.
- Response routing: `in_rsp_valid_o[out_rsp_id_i] = out_rsp_valid_i` and `out_rsp_ready_o = in_rsp_ready_i[out_rsp_id_i]`.
- On response handshake to port q: `outstanding[q]--`.
- Simultaneous request and response handshake on the same port leaves that counter unchanged.
- A response whose tag is ≥ `NR_FETCH_PORTS` is accepted and dropped (`out_rsp_ready_o=1`). No counter changes. Simulation asserts an error.
- A response arriving while the counter is 0 is a protocol violation: assertion fires and the counter stays at 0.
- Request addresses and IDs pass through unmodified. Ordering within a port is whatever the downstream returns; the block does not reorder.

## Timing
- Request path: combinational, 0 cycles from `in_valid_i` to `out_valid_o`.
- Response path: combinational, 0 cycles.
- Grant latch, `rr_ptr` and counters update on the rising edge after the handshake.
- Reset values:
  - All `in_ready_o` = 0, `in_rsp_valid_o` = 0, `out_valid_o` = 0.
  - `out_addr_o` = 0, `out_id_o` = 0, `out_rsp_ready_o` = 0.
  - `rr_ptr` = 0, state IDLE, all counters 0, `stall_cnt_o` = 0.
- While `rst_i` is high, all outputs are forced to their reset values.
- Reset asserted mid-transaction drops the lock and clears all counters. Responses still in flight after reset are the downstream's concern; the L1 is reset together with this block.
- Full: a port at `MAX_OUTSTANDING` is masked from arbitration. If it is currently LOCKED it stays granted, because it already satisfied eligibility at lock time.

## Configuration
- `SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN` defined:
  - Adds `stall_cnt_o`.
  - Counter p increments (16-bit, saturating at 0xFFFF) on each cycle with `in_valid_i[p]=1` and `in_ready_o[p]=0`.
  - Counters clear only on reset.
- Undefined: the port and the counters are absent, with zero area.

## Structure
- Shared package `snitch_icache_pkg` holds the arbiter state enum `refill_arb_state_e` (IDLE, LOCKED).
- `config_t` already supplies `NR_FETCH_PORTS`, `FETCH_AW`, `LINE_WIDTH` and `ID_WIDTH`. The top-level instantiation passes these from the cfg struct.
- One sub-module, `snitch_icache_rr_pick`: combinational round-robin priority selector taking an eligibility mask and `rr_ptr`, returning index and valid.

## Test plan
- Single port, stream of 3 requests with `out_ready_i=1` and `MAX_OUTSTANDING=2` → two requests accepted back-to-back; the third stalls until the first response returns with id=0.
- All 4 ports valid continuously, ready always high → grant order 0,1,2,3,0 and `out_id_o` matches.
- Port 2 granted with `out_ready_i=0` for 5 cycles while port 0 raises valid → `out_addr_o` and id stay at port 2 until handshake; port 0 is served next.
- Response id=3 with `in_rsp_ready_i[3]=0` for 2 cycles → `in_rsp_valid_o=4'b1000` held; counter 3 decrements only on the ready cycle.
- Same-cycle request handshake and response on port 1 → `outstanding[1]` unchanged.
- Macro on, port 1 stalled 10 cycles → `stall_cnt_o[1]=10`. Then assert `rst_i` mid-lock → all outputs 0 the next cycle and the counter clears.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: refill arbiter state and the cache configuration record.
package snitch_icache_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } refill_arb_state_e;

    typedef struct packed {
        logic [31:0] nr_fetch_ports;
        logic [31:0] fetch_aw;
        logic [31:0] line_width;
        logic [31:0] id_width;
    } config_t;

    // Wide enough for the largest allowed per-port in-flight limit (7).
    localparam int unsigned OUTSTANDING_CNT_W = 3;

endpackage

// File: rtl/snitch_icache_rr_pick.sv
// Combinational round-robin selector: first set bit of the mask at or after the pointer, wrapping.
module snitch_icache_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand_s;

    // Scan candidates starting at the pointer and keep the first eligible one.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_s = IW'((32'(ptr) + i) % N);
            if (!valid && mask[cand_s]) begin
                idx   = cand_s;
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/snitch_icache_refill_arbiter.sv
// Round-robin arbiter sharing the L1 lookup/refill port among the L0 miss handlers.
// Optional per-port stall counters are built when SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN is defined.
module snitch_icache_refill_arbiter
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS  = 4,
    parameter int unsigned FETCH_AW        = 32,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = $clog2(NR_FETCH_PORTS)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NR_FETCH_PORTS-1:0][FETCH_AW-1:0]  in_addr_i,
    input  logic [NR_FETCH_PORTS-1:0]                in_valid_i,
    output logic [NR_FETCH_PORTS-1:0]                in_ready_o,
    output logic [LINE_WIDTH-1:0]                    in_rsp_data_o,
    output logic                                     in_rsp_error_o,
    output logic [NR_FETCH_PORTS-1:0]                in_rsp_valid_o,
    input  logic [NR_FETCH_PORTS-1:0]                in_rsp_ready_i,
    output logic [FETCH_AW-1:0]                      out_addr_o,
    output logic [ID_WIDTH-1:0]                      out_id_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    input  logic [LINE_WIDTH-1:0]                    out_rsp_data_i,
    input  logic                                     out_rsp_error_i,
    input  logic [ID_WIDTH-1:0]                      out_rsp_id_i,
    input  logic                                     out_rsp_valid_i,
    output logic                                     out_rsp_ready_o
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
    ,
    output logic [NR_FETCH_PORTS-1:0][15:0]          stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = OUTSTANDING_CNT_W;

    refill_arb_state_e                        state_r;
    logic [ID_WIDTH-1:0]                      lock_idx_r;
    logic [ID_WIDTH-1:0]                      rr_ptr_r;
    logic [NR_FETCH_PORTS-1:0][CNT_W-1:0]     cnt_r;

    logic [NR_FETCH_PORTS-1:0]                eligible_s;
    logic [ID_WIDTH-1:0]                      pick_idx_s;
    logic                                     pick_valid_s;
    logic [ID_WIDTH-1:0]                      grant_idx_s;
    logic                                     grant_valid_s;
    logic                                     req_hs_s;
    logic                                     rsp_id_ok_s;
    logic                                     rsp_hs_s;
    logic                                     rsp_cnt_zero_s;
    logic [NR_FETCH_PORTS-1:0]                inc_s;
    logic [NR_FETCH_PORTS-1:0]                dec_s;

    // A full port is masked, but a port already locked keeps its grant below.
    always_comb begin
        for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
            eligible_s[p] = in_valid_i[p] && (cnt_r[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    snitch_icache_rr_pick #(
        .N  (NR_FETCH_PORTS),
        .IW (ID_WIDTH)
    ) i_rr_pick (
        .mask  (eligible_s),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Grant source: fresh pick when idle, latched port while locked.
    always_comb begin
        if (state_r == LOCKED) begin
            grant_idx_s   = lock_idx_r;
            grant_valid_s = in_valid_i[lock_idx_r];
        end else begin
            grant_idx_s   = pick_idx_s;
            grant_valid_s = pick_valid_s;
        end
    end

    assign rsp_id_ok_s = (32'(out_rsp_id_i) < NR_FETCH_PORTS);

    // Combinational request/response steering, forced to reset values while in reset.
    always_comb begin
        in_ready_o      = '0;
        out_addr_o      = '0;
        out_id_o        = '0;
        out_valid_o     = 1'b0;
        in_rsp_valid_o  = '0;
        out_rsp_ready_o = 1'b0;
        in_rsp_data_o   = '0;
        in_rsp_error_o  = 1'b0;
        if (!rst_i) begin
            in_rsp_data_o  = out_rsp_data_i;
            in_rsp_error_o = out_rsp_error_i;
            if (grant_valid_s) begin
                in_ready_o[grant_idx_s] = out_ready_i;
                out_addr_o              = in_addr_i[grant_idx_s];
                out_id_o                = grant_idx_s;
                out_valid_o             = 1'b1;
            end else begin
                out_valid_o = 1'b0;
            end
            // Out-of-range tags are swallowed so the downstream never blocks.
            if (rsp_id_ok_s) begin
                in_rsp_valid_o[out_rsp_id_i] = out_rsp_valid_i;
                out_rsp_ready_o              = in_rsp_ready_i[out_rsp_id_i];
            end else begin
                out_rsp_ready_o = 1'b1;
            end
        end else begin
            out_valid_o = 1'b0;
        end
    end

    assign req_hs_s       = out_valid_o && out_ready_i;
    assign rsp_hs_s       = out_rsp_valid_i && out_rsp_ready_o && rsp_id_ok_s;
    assign rsp_cnt_zero_s = rsp_id_ok_s && (cnt_r[out_rsp_id_i] == '0);

    // Per-port increment on request handshake, decrement on response handshake (never below 0).
    always_comb begin
        for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
            inc_s[p] = req_hs_s && (grant_idx_s == ID_WIDTH'(p));
            dec_s[p] = rsp_hs_s && (out_rsp_id_i == ID_WIDTH'(p)) && (cnt_r[p] != '0);
        end
    end

    // Arbitration FSM, round-robin pointer and outstanding counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            lock_idx_r <= '0;
            rr_ptr_r   <= '0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s && !out_ready_i) begin
                        state_r    <= LOCKED;
                        lock_idx_r <= grant_idx_s;
                    end
                end
                LOCKED: begin
                    if (req_hs_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
            if (req_hs_s) begin
                rr_ptr_r <= (grant_idx_s == ID_WIDTH'(NR_FETCH_PORTS - 1)) ? '0
                                                                           : grant_idx_s + ID_WIDTH'(1);
            end
            for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
                case ({inc_s[p], dec_s[p]})
                    2'b10:   cnt_r[p] <= cnt_r[p] + CNT_W'(1);
                    2'b01:   cnt_r[p] <= cnt_r[p] - CNT_W'(1);
                    default: cnt_r[p] <= cnt_r[p];
                endcase
            end
        end
    end

`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
    logic [NR_FETCH_PORTS-1:0][15:0] stall_cnt_r;

    // Saturating count of cycles each port waits with a pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= '0;
        end else begin
            for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
                if (in_valid_i[p] && !in_ready_o[p] && (stall_cnt_r[p] != 16'hFFFF)) begin
                    stall_cnt_r[p] <= stall_cnt_r[p] + 16'd1;
                end
            end
        end
    end

    assign stall_cnt_o = rst_i ? '0 : stall_cnt_r;
`endif

    snitch_icache_refill_arbiter_chk i_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rsp_fire     (out_rsp_valid_i && out_rsp_ready_o),
        .rsp_id_ok    (rsp_id_ok_s),
        .rsp_cnt_zero (rsp_cnt_zero_s)
    );

endmodule

// Protocol checks on the response side: tag range and no response without an outstanding miss.
module snitch_icache_refill_arbiter_chk (
    input logic clk_i,
    input logic rst_i,
    input logic rsp_fire,
    input logic rsp_id_ok,
    input logic rsp_cnt_zero
);

    rsp_tag_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_fire |-> rsp_id_ok);

    rsp_has_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_fire && rsp_id_ok) |-> !rsp_cnt_zero);

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// Directed, table-driven bench for the refill arbiter (4 ports, 2 outstanding per port).
// Stall-counter checks are compiled in when SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN is defined.
module tb_snitch_icache_refill_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam int unsigned IW = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NP-1:0][AW-1:0]    in_addr_i;
    logic [NP-1:0]            in_valid_i;
    logic [NP-1:0]            in_ready_o;
    logic [LW-1:0]            in_rsp_data_o;
    logic                     in_rsp_error_o;
    logic [NP-1:0]            in_rsp_valid_o;
    logic [NP-1:0]            in_rsp_ready_i;
    logic [AW-1:0]            out_addr_o;
    logic [IW-1:0]            out_id_o;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [LW-1:0]            out_rsp_data_i;
    logic                     out_rsp_error_i;
    logic [IW-1:0]            out_rsp_id_i;
    logic                     out_rsp_valid_i;
    logic                     out_rsp_ready_o;
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
    logic [NP-1:0][15:0]      stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    snitch_icache_refill_arbiter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .in_addr_i       (in_addr_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rsp_data_o   (in_rsp_data_o),
        .in_rsp_error_o  (in_rsp_error_o),
        .in_rsp_valid_o  (in_rsp_valid_o),
        .in_rsp_ready_i  (in_rsp_ready_i),
        .out_addr_o      (out_addr_o),
        .out_id_o        (out_id_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_rsp_data_i  (out_rsp_data_i),
        .out_rsp_error_i (out_rsp_error_i),
        .out_rsp_id_i    (out_rsp_id_i),
        .out_rsp_valid_i (out_rsp_valid_i),
        .out_rsp_ready_o (out_rsp_ready_o)
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    typedef struct {
        logic          rst;
        logic [NP-1:0] v;
        logic          ordy;
        logic          rv;
        logic [IW-1:0] rid;
        logic [NP-1:0] rrdy;
        logic [NP-1:0] ir;
        logic          ov;
        logic [IW-1:0] oid;
        logic [NP-1:0] rsv;
        logic          orr;
    } vec_t;

    vec_t          tbl[$];
    logic [AW-1:0] addr_tbl [NP];
    int            checks   = 0;
    int            failures = 0;

    function automatic vec_t mk(logic rst, logic [3:0] v, logic ordy, logic rv, logic [1:0] rid,
                                logic [3:0] rrdy, logic [3:0] ir, logic ov, logic [1:0] oid,
                                logic [3:0] rsv, logic orr);
        vec_t r;
        r.rst = rst; r.v = v; r.ordy = ordy; r.rv = rv; r.rid = rid; r.rrdy = rrdy;
        r.ir = ir; r.ov = ov; r.oid = oid; r.rsv = rsv; r.orr = orr;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        logic [LW-1:0] data_v;
        for (int p = 0; p < NP; p++) begin
            addr_tbl[p]  = 32'h8000_0000 + 32'(p) * 32'h0000_0140;
            in_addr_i[p] = addr_tbl[p];
        end
        rst_i           = 1'b1;
        in_valid_i      = 4'b0000;
        out_ready_i     = 1'b0;
        in_rsp_ready_i  = 4'b0000;
        out_rsp_data_i  = '0;
        out_rsp_error_i = 1'b0;
        out_rsp_id_i    = 2'd0;
        out_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // rst, v, ordy, rv, rid, rrdy | ir, ov, oid, rsv, orr
        tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 1'b1, 2'd2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h8, 1'b1, 2'd3, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 1'b1, 2'd2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 4'h8, 1'b1, 2'd3, 4'h0, 1'b1));
        // All ports full; response to port 3 held off for two cycles, then accepted.
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 4'h7, 4'h0, 1'b0, 2'd0, 4'h8, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 4'h7, 4'h0, 1'b0, 2'd0, 4'h8, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 2'd0, 4'h8, 1'b1));
        tbl.push_back(mk(1'b0, 4'h8, 1'b1, 1'b0, 2'd0, 4'hF, 4'h8, 1'b1, 2'd3, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h8, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1));
        // Single-port stream: two accepted, third waits for the id 0 response.
        tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        // Port 2 locked for five cycles while port 0 waits, then port 0 is next.
        tbl.push_back(mk(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h4, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 2'd2, 4'h0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 2'd2, 4'h0, 1'b1));
        end
        tbl.push_back(mk(1'b0, 4'h5, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 1'b1, 2'd2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h5, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 1'b1));
        // Same-cycle request and response on port 1 leaves its count at one.
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 1'b1, 2'd1, 4'hF, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 4'hB, 4'h0, 1'b0, 2'd0, 4'h4, 1'b0));

        foreach (tbl[i]) begin
            @(negedge clk_i);
            rst_i           = tbl[i].rst;
            in_valid_i      = tbl[i].v;
            out_ready_i     = tbl[i].ordy;
            out_rsp_valid_i = tbl[i].rv;
            out_rsp_id_i    = tbl[i].rid;
            in_rsp_ready_i  = tbl[i].rrdy;
            data_v          = {4{32'hC0DE_0000 ^ 32'(i)}};
            out_rsp_data_i  = data_v;
            out_rsp_error_i = (i % 2) == 1;
            #2;
            check("in_ready", i, LW'(in_ready_o), LW'(tbl[i].ir));
            check("out_valid", i, LW'(out_valid_o), LW'(tbl[i].ov));
            if (tbl[i].ov) begin
                check("out_id", i, LW'(out_id_o), LW'(tbl[i].oid));
                check("out_addr", i, LW'(out_addr_o), LW'(addr_tbl[tbl[i].oid]));
            end
            check("in_rsp_valid", i, LW'(in_rsp_valid_o), LW'(tbl[i].rsv));
            check("out_rsp_ready", i, LW'(out_rsp_ready_o), LW'(tbl[i].orr));
            check("rsp_data", i, in_rsp_data_o, tbl[i].rst ? '0 : data_v);
            check("rsp_error", i, LW'(in_rsp_error_o), LW'(!tbl[i].rst && ((i % 2) == 1)));
            if (tbl[i].rst) begin
                check("rst_out_addr", i, LW'(out_addr_o), '0);
                check("rst_out_id", i, LW'(out_id_o), '0);
            end
        end

        // Port 1 locked and stalled ten cycles, then reset dropped mid-lock.
        @(negedge clk_i);
        rst_i           = 1'b1;
        in_valid_i      = 4'h0;
        out_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i       = 1'b0;
        in_valid_i  = 4'h2;
        out_ready_i = 1'b0;
        #1;
        check("lock_p1_valid", 100, LW'(out_valid_o), LW'(1'b1));
        check("lock_p1_id", 100, LW'(out_id_o), LW'(2'd1));
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        #1;
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
        check("stall_cnt1", 101, LW'(stall_cnt_o[1]), LW'(16'd10));
        check("stall_cnt0", 101, LW'(stall_cnt_o[0]), LW'(16'd0));
`endif
        rst_i           = 1'b1;
        in_valid_i      = 4'h3;
        out_ready_i     = 1'b1;
        out_rsp_valid_i = 1'b1;
        out_rsp_id_i    = 2'd1;
        #1;
        check("mid_rst_ready", 102, LW'(in_ready_o), '0);
        check("mid_rst_valid", 102, LW'(out_valid_o), '0);
        check("mid_rst_addr", 102, LW'(out_addr_o), '0);
        check("mid_rst_rsp_valid", 102, LW'(in_rsp_valid_o), '0);
        check("mid_rst_rsp_ready", 102, LW'(out_rsp_ready_o), '0);
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
        check("mid_rst_stall", 102, LW'(stall_cnt_o), '0);
`endif
        @(negedge clk_i);
        rst_i           = 1'b0;
        out_rsp_valid_i = 1'b0;
        #1;
        check("post_rst_id", 103, LW'(out_id_o), LW'(2'd0));
        check("post_rst_ready", 103, LW'(in_ready_o), LW'(4'h1));
`ifdef SNITCH_ICACHE_REFILL_ARB_STALL_CNT_EN
        check("post_rst_stall1", 103, LW'(stall_cnt_o[1]), LW'(16'd0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
